// File: rtl/requant_pipe_pkg.sv
// Shared widths and mode encoding for the requantizer datapath.
package requant_pipe_pkg;

  localparam int unsigned BIAS_WIDTH = 20;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned QSHIFT_W   = 5;

  typedef enum logic [1:0] {
    QmodeTrunc = 2'd0,
    QmodeSat   = 2'd1,
    QmodeRelu  = 2'd2,
    QmodeRsvd  = 2'd3
  } qmode_e;

endpackage

// File: rtl/requant_lane.sv
// One requantizer lane: S1 rounds and shifts, S2 clamps, applies ReLU and flags saturation.
module requant_lane
  import requant_pipe_pkg::*;
#(
  parameter int unsigned IN_W   = BIAS_WIDTH,
  parameter int unsigned OUT_W  = DATA_WIDTH,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned SH_W   = $clog2(BIAS_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  qmode_e            mode,
  input  logic [SH_W-1:0]   shift,
  input  logic [IN_W-1:0]   din,
  output logic [OUT_W-1:0]  dout,
  output logic              sat
);

  localparam int unsigned TW = IN_W + 1;

  logic [IN_W:0]    ext, rnd, t, r_d, r_q;
  qmode_e           mode_q;
  logic [OUT_W-1:0] dout_d, dout_q;
  logic             sat_d, sat_q, neg, over;

  always_comb begin
    ext = (SIGNED != 0) ? {din[IN_W-1], din} : {1'b0, din};
    rnd = '0;
    if (shift != '0) rnd = TW'(1) << (shift - 1'b1);
    t = ext + rnd;
    if (mode == QmodeTrunc) r_d = TW'(din[OUT_W-1:0]);
    else if (SIGNED != 0)   r_d = $signed(t) >>> shift;
    else                    r_d = t >> shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      mode_q <= QmodeTrunc;
    end else if (en) begin
      r_q    <= r_d;
      mode_q <= mode;
    end
  end

  // Signed result fits when all bits from the output sign bit upward agree.
  always_comb begin
    dout_d = r_q[OUT_W-1:0];
    sat_d  = 1'b0;
    neg    = 1'b0;
    over   = 1'b0;
    if (mode_q != QmodeTrunc) begin
      if (SIGNED != 0) begin
        neg  = r_q[IN_W];
        over = !((&r_q[IN_W:OUT_W-1]) || !(|r_q[IN_W:OUT_W-1]));
        if (over) dout_d = neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        sat_d = over;
        if (mode_q == QmodeRelu && neg) begin
          dout_d = '0;
          sat_d  = 1'b0;
        end
      end else begin
        over = |r_q[IN_W:OUT_W];
        if (over) dout_d = '1;
        sat_d = over;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else if (en) begin
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout = dout_q;
  assign sat  = sat_q;

endmodule

// File: rtl/requant_pipe.sv
// Two-stage requantizer with a single global stall and a sticky saturation event counter.
module requant_pipe
  import requant_pipe_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned IN_W    = BIAS_WIDTH,
  parameter int unsigned OUT_W   = DATA_WIDTH,
  parameter int unsigned SIGNED  = 0,
  parameter int unsigned SHIFT_W = QSHIFT_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cfg_mode,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_cnt
);

  localparam int unsigned SH_W = $clog2(IN_W);

  logic             en, v1_q, v2_q;
  logic [SH_W-1:0]  shift_c;
  logic [LANES-1:0] lane_sat;
  logic [CNT_W-1:0] cnt_q;

  assign en        = !v2_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v2_q;
  assign sat_cnt   = cnt_q;

  always_comb begin
    if (32'(cfg_shift) > IN_W - 1) shift_c = SH_W'(IN_W - 1);
    else                           shift_c = SH_W'(cfg_shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .SIGNED (SIGNED),
      .SH_W   (SH_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (qmode_e'(cfg_mode)),
      .shift (shift_c),
      .din   (in_data[i*IN_W +: IN_W]),
      .dout  (out_data[i*OUT_W +: OUT_W]),
      .sat   (lane_sat[i])
    );
  end

  // Clear has priority; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (sat_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && (|lane_sat) && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/requant_pipe.md
Name: requant_pipe

Overview:
- Parametrised, pipelined requantizer. Converts LANES wide accumulator/bias-sum words (IN_W bits each) into OUT_W-bit activations.
- Three modes:
  - legacy truncation;
  - shift with round-half-up and saturation;
  - shift, round, saturate, then ReLU.
- Sits between the bias-add stage and the activation buffer of the CAE datapath.
- Adds valid/ready flow control and a saturation event counter.

Parameters:
- LANES, 4, number of parallel channels per beat.
- IN_W, `BIAS_WIDTH, input word width per lane.
- OUT_W, `DATA_WIDTH, output word width per lane.
- SIGNED, 0, 1 = two's-complement input/output; 0 = unsigned.
- SHIFT_W, 5, width of the cfg_shift port.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_mode  in  2  0=truncate, 1=shift/round/saturate, 2=shift/round/saturate/ReLU, 3=reserved (treated as 1).
- cfg_shift  in  SHIFT_W  right-shift amount; values above IN_W-1 are clamped to IN_W-1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*IN_W  lane i at bits [i*IN_W +: IN_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W].
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  number of output beats in which any lane saturated.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, sat_cnt=0, all internal valid bits=0. in_ready is 1 while rst is high.
- Pipeline: two register stages, S1 then S2. Latency is exactly 2 cycles from input handshake to out_valid when there is no stall.
- Global advance enable: en = !out_valid || out_ready. in_ready = en. Both stages advance only when en=1.
  - A bubble in S1 propagates as out_valid=0.
  - out_data holds stable while out_valid=1 and out_ready=0.
- cfg_mode and cfg_shift are sampled with in_data at the input handshake and carried through the pipe. A config change therefore never affects beats already in flight.
- S1, per lane:
  - Mode 0: pass din[OUT_W-1:0]; no saturation.
  - Modes 1/2: t = ext(din) + (s>0 ? 2^(s-1) : 0), computed at IN_W+1 bits.
    - ext = sign- or zero-extension per SIGNED.
    - s is the clamped shift.
    - r = t >> s, arithmetic shift when SIGNED=1.
- S2, per lane:
  - Clamp r to the output range:
    - unsigned: [0, 2^OUT_W-1];
    - signed: [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - lane_sat=1 if clamping occurred.
  - Mode 2 with SIGNED=1: negative results become 0; this does not count as saturation.
  - Mode 2 with SIGNED=0: behaves as mode 1.
- Counter: on each output handshake (out_valid && out_ready) with any lane_sat=1, sat_cnt increments by 1. It sticks at all-ones and does not wrap.
  - sat_clr=1 sets sat_cnt to 0 next cycle.
  - sat_clr wins over a same-cycle increment.
- Rounding is round-half-up toward +inf (e.g. -2.5 becomes -2).
- Simultaneous input and output handshake in the same cycle: full throughput, 1 beat/cycle.

Decomposition:
- parameters.v gains:
  - `QMODE_TRUNC=2'd0, `QMODE_SAT=2'd1, `QMODE_RELU=2'd2;
  - `QSHIFT_W=5.
- LANES, IN_W and OUT_W default from the existing `BIAS_WIDTH and `DATA_WIDTH.
- One sub-module, requant_lane: the per-lane S1/S2 arithmetic plus the lane_sat flag. It is instantiated LANES times via generate.
- Handshake, enable logic and the counter stay in requant_pipe.

Test Plan (IN_W=20, OUT_W=8, LANES=4 unless noted):
- Unsigned, mode 1, shift 12, din=0x12800 -> 0x13 two cycles later. sat_cnt stays 0.
- Unsigned, mode 1, shift 12, din=0xFF800 -> rounds to 0x100, clamps to 0xFF. sat_cnt=1 after the handshake.
- SIGNED=1, mode 1, shift 4: din=-40 -> 0xFE (-2); din=-3000 -> 0x80 (-128), sat. Same beat in mode 2: both lanes 0x00, no sat increment from ReLU alone.
- Mode 0, din=0xABCDE -> 0xDE, no sat. Then switch to mode 1 on the next beat -> the earlier beat still emerges as 0xDE.
- Backpressure: stream 6 beats with out_ready low for cycles 3-5 -> in_ready low while stalled, out_data stable, all 6 beats delivered in order with no loss or duplication.
- Reset mid-stream with 2 beats in flight -> out_valid drops immediately, sat_cnt=0. sat_clr coincident with a saturating handshake -> sat_cnt=0.
